// File: rtl/lp_ctrl_pkg.sv
// Shared definitions for the LP run controller: register map, STATUS bits,
// run-sequencer states and the AXI response code.
package lp_ctrl_pkg;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_TIMEOUT = 2'd2;
    localparam logic [1:0] REG_ELAPSED = 2'd3;

    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_TIMEOUT = 2;
    localparam int ST_ABORTED = 3;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_FINISH
    } run_state_e;

endpackage

// File: rtl/lp_axil_regif.sv
// AXI-Lite slave for the run controller: single-beat handshakes, register
// decode, TIMEOUT_US storage and command/W1C strobes toward the sequencer.
module lp_axil_regif
    import lp_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] S_AXI_AWADDR,
    input  logic              S_AXI_AWVALID,
    output logic              S_AXI_AWREADY,
    input  logic [31:0]       S_AXI_WDATA,
    input  logic [3:0]        S_AXI_WSTRB,
    input  logic              S_AXI_WVALID,
    output logic              S_AXI_WREADY,
    output logic [1:0]        S_AXI_BRESP,
    output logic              S_AXI_BVALID,
    input  logic              S_AXI_BREADY,
    input  logic [ADDR_W-1:0] S_AXI_ARADDR,
    input  logic              S_AXI_ARVALID,
    output logic              S_AXI_ARREADY,
    output logic [31:0]       S_AXI_RDATA,
    output logic [1:0]        S_AXI_RRESP,
    output logic              S_AXI_RVALID,
    input  logic              S_AXI_RREADY,
    input  logic [3:0]        status_i,
    input  logic [31:0]       elapsed_i,
    output logic              start_o,
    output logic              abort_o,
    output logic [2:0]        w1c_o,
    output logic [31:0]       timeout_us_o
);

    logic        bvalid_q, bvalid_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] timeout_q, timeout_d;
    logic        wr_hs, rd_hs;
    logic [1:0]  wr_sel, rd_sel;

    // NOTE: ready is a combinational decode of valid and the response slot, so
    // the accepting edge is also the edge on which the register updates.
    assign wr_hs  = S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q;
    assign rd_hs  = S_AXI_ARVALID & ~rvalid_q;
    assign wr_sel = S_AXI_AWADDR[3:2];
    assign rd_sel = S_AXI_ARADDR[3:2];

    assign S_AXI_AWREADY = wr_hs;
    assign S_AXI_WREADY  = wr_hs;
    assign S_AXI_ARREADY = rd_hs;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_BRESP   = RESP_OKAY;
    assign S_AXI_RRESP   = RESP_OKAY;

    assign start_o      = wr_hs && (wr_sel == REG_CTRL) && S_AXI_WDATA[0];
    assign abort_o      = wr_hs && (wr_sel == REG_CTRL) && S_AXI_WDATA[1];
    assign w1c_o        = (wr_hs && (wr_sel == REG_STATUS)) ? S_AXI_WDATA[3:1] : 3'b000;
    assign timeout_us_o = timeout_q;

    // NOTE: every always_comb output takes its hold value first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        bvalid_d  = bvalid_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        timeout_d = timeout_q;
        if (wr_hs)             bvalid_d = 1'b1;
        else if (S_AXI_BREADY) bvalid_d = 1'b0;
        if (rd_hs)             rvalid_d = 1'b1;
        else if (S_AXI_RREADY) rvalid_d = 1'b0;
        if (wr_hs && (wr_sel == REG_TIMEOUT)) begin
            for (int b = 0; b < 4; b++) begin
                if (S_AXI_WSTRB[b]) timeout_d[8*b +: 8] = S_AXI_WDATA[8*b +: 8];
            end
        end
        if (rd_hs) begin
            case (rd_sel)
                REG_STATUS:  rdata_d = {28'd0, status_i};
                REG_TIMEOUT: rdata_d = timeout_q;
                REG_ELAPSED: rdata_d = elapsed_i;
                default:     rdata_d = 32'd0;
            endcase
        end
    end

    // NOTE: state flops use non-blocking assignment so every flop samples the
    // pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'd0;
            timeout_q <= 32'd0;
        end else begin
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            timeout_q <= timeout_d;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                           S_AXI_AWADDR[ADDR_W-1:4], S_AXI_ARADDR[ADDR_W-1:4]};

endmodule

// File: rtl/lp_run_ctrl.sv
// LP run sequencer: launches the solver, counts microseconds while running,
// and closes the run on solver completion, watchdog timeout or software abort.
module lp_run_ctrl
    import lp_ctrl_pkg::*;
#(
    parameter int CLKS_PER_US = 100,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] S_AXI_AWADDR,
    input  logic              S_AXI_AWVALID,
    output logic              S_AXI_AWREADY,
    input  logic [31:0]       S_AXI_WDATA,
    input  logic [3:0]        S_AXI_WSTRB,
    input  logic              S_AXI_WVALID,
    output logic              S_AXI_WREADY,
    output logic [1:0]        S_AXI_BRESP,
    output logic              S_AXI_BVALID,
    input  logic              S_AXI_BREADY,
    input  logic [ADDR_W-1:0] S_AXI_ARADDR,
    input  logic              S_AXI_ARVALID,
    output logic              S_AXI_ARREADY,
    output logic [31:0]       S_AXI_RDATA,
    output logic [1:0]        S_AXI_RRESP,
    output logic              S_AXI_RVALID,
    input  logic              S_AXI_RREADY,
    input  logic              solver_done,
    output logic              lp_start,
    output logic              lp_end,
    output logic              solver_abort,
    output logic              irq
);

    localparam int PW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLKS_PER_US - 1);

    run_state_e  state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [31:0] elapsed_q, elapsed_d;
    logic        done_q, done_d, tmo_q, tmo_d, abt_q, abt_d;
    logic        start_cmd, abort_cmd, timeout_hit;
    logic [2:0]  w1c;
    logic [31:0] timeout_us;
    logic [3:0]  status;

    assign status = {abt_q, tmo_q, done_q, state_q == S_RUN};
    assign irq    = done_q | tmo_q | abt_q;
    assign timeout_hit = (timeout_us != 32'd0) && (elapsed_q == timeout_us);

    lp_axil_regif #(.ADDR_W(ADDR_W)) u_regif (
        .clk           (clk),
        .reset         (reset),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .status_i      (status),
        .elapsed_i     (elapsed_q),
        .start_o       (start_cmd),
        .abort_o       (abort_cmd),
        .w1c_o         (w1c),
        .timeout_us_o  (timeout_us)
    );

    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        elapsed_d    = elapsed_q;
        // Clear first, then any set below overrides a same-edge W1C.
        done_d       = done_q & ~w1c[0];
        tmo_d        = tmo_q  & ~w1c[1];
        abt_d        = abt_q  & ~w1c[2];
        lp_start     = 1'b0;
        lp_end       = 1'b0;
        solver_abort = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_cmd) begin
                    done_d    = 1'b0;
                    tmo_d     = 1'b0;
                    abt_d     = 1'b0;
                    elapsed_d = 32'd0;
                    presc_d   = '0;
                    state_d   = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                lp_start = 1'b1;
                state_d  = S_RUN;
            end
            S_RUN: begin
                if (solver_done) begin
                    done_d  = 1'b1;
                    state_d = S_FINISH;
                end else if (timeout_hit) begin
                    tmo_d        = 1'b1;
                    solver_abort = 1'b1;
                    state_d      = S_FINISH;
                end else if (abort_cmd) begin
                    abt_d        = 1'b1;
                    solver_abort = 1'b1;
                    state_d      = S_FINISH;
                end else if (presc_q == PRESC_MAX) begin
                    presc_d = '0;
                    if (elapsed_q != 32'hFFFF_FFFF) elapsed_d = elapsed_q + 32'd1;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            S_FINISH: begin
                lp_end  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            presc_q   <= '0;
            elapsed_q <= 32'd0;
            done_q    <= 1'b0;
            tmo_q     <= 1'b0;
            abt_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            elapsed_q <= elapsed_d;
            done_q    <= done_d;
            tmo_q     <= tmo_d;
            abt_q     <= abt_d;
        end
    end

endmodule
